// File: rtl/gray_ptr_fifo.sv
// 16x16 FIFO with Gray-coded pointers and 2-flop pointer synchronizers; rdata falls through combinationally.
// Full/empty are registered and pessimistic: the opposite pointer is seen 2 cycles late, so the FIFO never overflows or underflows.
module gray_ptr_fifo #(
  parameter int DATASIZE = 16,
  parameter int ADDRSIZE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                winc,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                wfull,
  output logic                rempty
);

  localparam int DEPTH = 1 << ADDRSIZE;

  logic [DATASIZE-1:0] mem_q [DEPTH];

  logic [ADDRSIZE:0] wbin_q, wbin_d, wptr_q, wptr_d;
  logic [ADDRSIZE:0] rbin_q, rbin_d, rptr_q, rptr_d;
  logic [ADDRSIZE:0] rq1_wptr_q, rq2_wptr_q;
  logic [ADDRSIZE:0] wq1_rptr_q, wq2_rptr_q;
  logic              wfull_q, wfull_d;
  logic              rempty_q, rempty_d;
  logic              wr_en, rd_en;

  // Write side
  assign wr_en   = winc & ~wfull_q;
  assign wbin_d  = wbin_q + {{ADDRSIZE{1'b0}}, wr_en};
  assign wptr_d  = (wbin_d >> 1) ^ wbin_d;
  // Full when the next write pointer equals the synced read pointer with its two MSBs inverted.
  assign wfull_d = (wptr_d == {~wq2_rptr_q[ADDRSIZE:ADDRSIZE-1], wq2_rptr_q[ADDRSIZE-2:0]});

  // Read side
  assign rd_en    = rinc & ~rempty_q;
  assign rbin_d   = rbin_q + {{ADDRSIZE{1'b0}}, rd_en};
  assign rptr_d   = (rbin_d >> 1) ^ rbin_d;
  assign rempty_d = (rptr_d == rq2_wptr_q);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wbin_q[ADDRSIZE-1:0]] <= wdata;
    end
  end

  assign rdata  = mem_q[rbin_q[ADDRSIZE-1:0]];
  assign wfull  = wfull_q;
  assign rempty = rempty_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      wfull_q <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wptr_d;
      wfull_q <= wfull_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
    end
  end

  // Kept as true synchronizers so the two sides can move to separate clocks later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq1_wptr_q <= '0;
      rq2_wptr_q <= '0;
      wq1_rptr_q <= '0;
      wq2_rptr_q <= '0;
    end else begin
      rq1_wptr_q <= wptr_q;
      rq2_wptr_q <= rq1_wptr_q;
      wq1_rptr_q <= rptr_q;
      wq2_rptr_q <= wq1_rptr_q;
    end
  end

endmodule

// File: tb/tb_gray_ptr_fifo.sv
// Directed bench for gray_ptr_fifo: reset, flag latencies, fill/overflow, mixed traffic, wrap and mid-run reset.
module tb_gray_ptr_fifo;

  logic        clk;
  logic        rst;
  logic [15:0] wdata;
  logic        winc;
  logic        rinc;
  logic [15:0] rdata;
  logic        wfull;
  logic        rempty;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] q[$];
  logic [15:0] exp_word;

  gray_ptr_fifo #(.DATASIZE(16), .ADDRSIZE(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .wdata  (wdata),
    .winc   (winc),
    .rinc   (rinc),
    .rdata  (rdata),
    .wfull  (wfull),
    .rempty (rempty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reads until the model queue is empty; every accepted read is compared to the model.
  task automatic drain(input string tag);
    int guard;
    guard = 0;
    winc = 1'b0;
    while (q.size() > 0 && guard < 200) begin
      if (!rempty) begin
        exp_word = q.pop_front();
        check(tag, rdata, exp_word);
        rinc = 1'b1;
      end else begin
        rinc = 1'b0;
      end
      tick();
      guard++;
    end
    rinc = 1'b0;
    if (guard >= 200) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s_timeout: observed %0d words left expected 0", tag, q.size());
    end
    repeat (3) tick();
    check({tag, "_empty_after"}, {15'd0, rempty}, 16'd1);
  endtask

  initial begin
    // Reset with requests active: nothing may be written or read
    rst   = 1'b1;
    winc  = 1'b1;
    rinc  = 1'b1;
    wdata = 16'hDEAD;
    #2;
    check("rst_async_rempty", {15'd0, rempty}, 16'd1);
    check("rst_async_wfull",  {15'd0, wfull},  16'd0);
    repeat (5) tick();
    check("rst_hold_rempty", {15'd0, rempty}, 16'd1);
    check("rst_hold_wfull",  {15'd0, wfull},  16'd0);
    winc = 1'b0;
    rinc = 1'b0;
    rst  = 1'b0;
    repeat (4) tick();
    check("post_rst_rempty", {15'd0, rempty}, 16'd1);

    // Single word: rempty clears after edge k+3
    wdata = 16'hA5C3;
    winc  = 1'b1;
    tick();
    winc = 1'b0;
    check("single_k0_rempty", {15'd0, rempty}, 16'd1);
    tick();
    check("single_k1_rempty", {15'd0, rempty}, 16'd1);
    tick();
    check("single_k2_rempty", {15'd0, rempty}, 16'd1);
    tick();
    check("single_k3_rempty", {15'd0, rempty}, 16'd0);
    check("single_rdata", rdata, 16'hA5C3);
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    check("single_read_rempty", {15'd0, rempty}, 16'd1);
    repeat (3) tick();

    // Fill: 16 writes, 17th dropped, then read back with wfull latency
    for (int i = 0; i < 16; i++) begin
      wdata = 16'(i);
      winc  = 1'b1;
      tick();
      if (i == 14) check("fill_15_wfull", {15'd0, wfull}, 16'd0);
    end
    check("fill_16_wfull", {15'd0, wfull}, 16'd1);
    wdata = 16'hFFFF;
    tick();
    winc = 1'b0;
    check("fill_17_wfull", {15'd0, wfull}, 16'd1);
    check("fill_rempty", {15'd0, rempty}, 16'd0);
    for (int i = 0; i < 16; i++) begin
      check("fill_rdata", rdata, 16'(i));
      rinc = 1'b1;
      tick();
      if (i < 3)  check("drain_wfull_held", {15'd0, wfull}, 16'd1);
      if (i == 3) check("drain_wfull_k3",   {15'd0, wfull}, 16'd0);
      if (i < 15) check("drain_rempty_low", {15'd0, rempty}, 16'd0);
    end
    rinc = 1'b0;
    check("drain_rempty_last", {15'd0, rempty}, 16'd1);
    repeat (3) tick();

    // Alternating traffic: write on even cycles, read on odd cycles
    q.delete();
    for (int c = 0; c < 64; c++) begin
      winc  = (c % 2 == 0);
      rinc  = (c % 2 == 1);
      wdata = 16'($urandom);
      if (rinc && !rempty) begin
        exp_word = q.pop_front();
        check("alt_rdata", rdata, exp_word);
      end
      if (winc && !wfull) q.push_back(wdata);
      tick();
      check("alt_wfull", {15'd0, wfull}, 16'd0);
    end
    drain("alt_drain");

    // Steady stream of 40 words, simultaneous read and write, across pointer wrap
    q.delete();
    for (int c = 0; c < 40; c++) begin
      winc  = 1'b1;
      rinc  = 1'b1;
      wdata = 16'h5000 + 16'(c * 3);
      if (!rempty) begin
        exp_word = q.pop_front();
        check("wrap_rdata", rdata, exp_word);
      end
      q.push_back(wdata);
      tick();
      check("wrap_wfull", {15'd0, wfull}, 16'd0);
      if (c >= 3) check("wrap_rempty", {15'd0, rempty}, 16'd0);
    end
    drain("wrap_drain");

    // Mid-operation reset with 5 words stored
    for (int i = 0; i < 5; i++) begin
      wdata = 16'h0100 + 16'(i);
      winc  = 1'b1;
      tick();
    end
    winc = 1'b0;
    repeat (3) tick();
    check("mid_pre_rempty", {15'd0, rempty}, 16'd0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_rempty", {15'd0, rempty}, 16'd1);
    check("mid_rst_wfull",  {15'd0, wfull},  16'd0);
    tick();
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 3; i++) begin
      wdata = 16'h7000 + 16'(i);
      winc  = 1'b1;
      q.push_back(wdata);
      tick();
    end
    winc = 1'b0;
    repeat (3) tick();
    check("mid_post_rempty", {15'd0, rempty}, 16'd0);
    check("mid_post_head", rdata, 16'h7000);
    drain("mid_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
